// File: rtl/systolic_array_ctrl_4x4_pkg.sv
// Shared definitions for the systolic array sequencers: state encoding,
// default sizing and the phase-length formulas reused by larger arrays.
package systolic_array_ctrl_4x4_pkg;

  localparam int N_DEF          = 4;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int CNT_W_DEF      = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CLEAR  = 3'd2,
    S_FEED   = 3'd3,
    S_DRAIN  = 3'd4,
    S_RESULT = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  // Skewed wavefront: the last operand enters row/col N-1 after 2*(N-1) extra cycles.
  function automatic int feed_cycles(input int n);
    return 3 * n - 2;
  endfunction

  function automatic int drain_cycles(input int n);
    return n;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/systolic_array_ctrl_4x4_phase_counter.sv
// Loadable up-counter with a terminal-count flag; used for operand
// loading and for the feed/drain phase timing.
module sa_phase_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == term_i);

endmodule

// File: rtl/systolic_array_ctrl_4x4.sv
// Job sequencer for the 4x4 systolic array: load operands, clear, feed,
// drain, capture result. All outputs come straight from flops.
module systolic_array_ctrl_4x4
  import systolic_array_ctrl_4x4_pkg::*;
#(
  parameter int N            = N_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int FEED_CYCLES  = feed_cycles(N),
  parameter int DRAIN_CYCLES = drain_cycles(N),
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_a,
  input  logic [DATA_WIDTH-1:0]    in_b,
  output logic                     buf_wr_en,
  output logic [$clog2(N*N)-1:0]   buf_wr_addr,
  output logic [DATA_WIDTH-1:0]    buf_wr_a,
  output logic [DATA_WIDTH-1:0]    buf_wr_b,
  output logic                     arr_rst,
  output logic                     buf_read,
  output logic [CNT_W-1:0]         feed_step,
  output logic                     result_ld,
  output logic                     busy,
  output logic                     done
);

  localparam int AW       = $clog2(N*N);
  localparam int CNT_NEED = max3(N * N, FEED_CYCLES, DRAIN_CYCLES);

  if (CNT_NEED >= (1 << CNT_W)) begin : g_cnt_w_too_narrow
    $error("CNT_W too narrow for N*N, FEED_CYCLES and DRAIN_CYCLES");
  end

  state_e state_q, state_d;

  logic [CNT_W-1:0] load_cnt, phase_cnt, phase_term;
  logic             load_tc, phase_tc, xfer;

  logic                  in_ready_q, in_ready_d;
  logic                  buf_wr_en_q, buf_wr_en_d;
  logic [AW-1:0]         buf_wr_addr_q, buf_wr_addr_d;
  logic [DATA_WIDTH-1:0] buf_wr_a_q, buf_wr_a_d, buf_wr_b_q, buf_wr_b_d;
  logic                  arr_rst_q, arr_rst_d, buf_read_q, buf_read_d;
  logic [CNT_W-1:0]      feed_step_q, feed_step_d;
  logic                  result_ld_q, result_ld_d, busy_q, busy_d, done_q, done_d;

  // The count bound is redundant with in_ready but guarantees no 17th write.
  assign xfer = in_valid && in_ready_q && (load_cnt < CNT_W'(N * N));

  sa_phase_counter #(.W(CNT_W)) u_load_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == S_IDLE),
    .load_val_i ('0),
    .en_i       (xfer),
    .term_i     (CNT_W'(N * N - 1)),
    .count_o    (load_cnt),
    .tc_o       (load_tc)
  );

  // One counter times both FEED and DRAIN; it is reloaded on each phase entry.
  assign phase_term = (state_q == S_FEED) ? CNT_W'(FEED_CYCLES - 1) : CNT_W'(DRAIN_CYCLES - 1);

  sa_phase_counter #(.W(CNT_W)) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     ((state_q == S_CLEAR) || ((state_q == S_FEED) && phase_tc)),
    .load_val_i ('0),
    .en_i       ((state_q == S_FEED) || (state_q == S_DRAIN)),
    .term_i     (phase_term),
    .count_o    (phase_cnt),
    .tc_o       (phase_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: default assignment first so every path drives state_d -- no latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD:   if (xfer && load_tc) state_d = S_CLEAR;
      S_CLEAR:  state_d = S_FEED;
      S_FEED:   if (phase_tc) state_d = S_DRAIN;
      S_DRAIN:  if (phase_tc) state_d = S_RESULT;
      S_RESULT: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it once registered.
  always_comb begin
    in_ready_d    = (state_d == S_LOAD);
    buf_wr_en_d   = xfer;
    buf_wr_addr_d = xfer ? load_cnt[AW-1:0] : buf_wr_addr_q;
    buf_wr_a_d    = xfer ? in_a : buf_wr_a_q;
    buf_wr_b_d    = xfer ? in_b : buf_wr_b_q;
    arr_rst_d     = (state_d == S_CLEAR);
    buf_read_d    = (state_d == S_FEED);
    feed_step_d   = '0;
    if ((state_d == S_FEED) && (state_q == S_FEED)) begin
      feed_step_d = phase_cnt + CNT_W'(1);
    end
    result_ld_d   = (state_d == S_RESULT);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q    <= 1'b0;
      buf_wr_en_q   <= 1'b0;
      buf_wr_addr_q <= '0;
      buf_wr_a_q    <= '0;
      buf_wr_b_q    <= '0;
      arr_rst_q     <= 1'b0;
      buf_read_q    <= 1'b0;
      feed_step_q   <= '0;
      result_ld_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      in_ready_q    <= in_ready_d;
      buf_wr_en_q   <= buf_wr_en_d;
      buf_wr_addr_q <= buf_wr_addr_d;
      buf_wr_a_q    <= buf_wr_a_d;
      buf_wr_b_q    <= buf_wr_b_d;
      arr_rst_q     <= arr_rst_d;
      buf_read_q    <= buf_read_d;
      feed_step_q   <= feed_step_d;
      result_ld_q   <= result_ld_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign buf_wr_en   = buf_wr_en_q;
  assign buf_wr_addr = buf_wr_addr_q;
  assign buf_wr_a    = buf_wr_a_q;
  assign buf_wr_b    = buf_wr_b_q;
  assign arr_rst     = arr_rst_q;
  assign buf_read    = buf_read_q;
  assign feed_step   = feed_step_q;
  assign result_ld   = result_ld_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_systolic_array_ctrl_4x4.sv
// Bench for systolic_array_ctrl_4x4: a timeline model (edge of start acceptance,
// edge of the last operand write) predicts every output on every cycle.
module tb_systolic_array_ctrl_4x4;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int NN    = N * N;
  localparam int FEED  = 3 * N - 2;
  localparam int DRAIN = N;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [DW-1:0] in_a, in_b;
  logic          in_ready, buf_wr_en, arr_rst, buf_read, result_ld, busy, done;
  logic [3:0]    buf_wr_addr;
  logic [DW-1:0] buf_wr_a, buf_wr_b;
  logic [7:0]    feed_step;

  systolic_array_ctrl_4x4 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .buf_wr_a    (buf_wr_a),
    .buf_wr_b    (buf_wr_b),
    .arr_rst     (arr_rst),
    .buf_read    (buf_read),
    .feed_step   (feed_step),
    .result_ld   (result_ld),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: a job is described by the edge that accepted start (t_s) and
  // the edge that accepted the NN-th operand pair (t_w); everything else is an offset.
  int            edge_n   = 0;
  bit            m_known  = 0;
  bit            m_active = 0;
  int            t_s      = 0;
  int            t_w      = -1;
  int            n_wr     = 0;
  bit            m_wr     = 0;
  int            m_addr   = 0;
  logic [DW-1:0] m_a, m_b;

  task automatic model_step();
    edge_n++;
    m_wr = 0;
    if (rst) begin
      m_known  = 1;
      m_active = 0;
      t_w      = -1;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1;
        t_s      = edge_n;
        n_wr     = 0;
        t_w      = -1;
      end
    end else if (t_w < 0) begin
      if (in_valid) begin
        m_wr   = 1;
        m_addr = n_wr;
        m_a    = in_a;
        m_b    = in_b;
        n_wr++;
        if (n_wr == NN) t_w = edge_n;
      end
    end else if (edge_n == t_w + FEED + DRAIN + 3) begin
      m_active = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Pulse counters for literal per-job checks, and a flag enabling data pinning.
  int cnt_wr, cnt_arr, cnt_read, cnt_res, cnt_done;
  bit nominal_data = 0;

  task automatic compare();
    bit ph;
    int e_step;
    if (!m_known) return;
    ph     = m_active && (t_w >= 0);
    e_step = (ph && edge_n > t_w && edge_n <= t_w + FEED) ? edge_n - t_w - 1 : 0;
    check("in_ready",  32'(in_ready),  32'(m_active && t_w < 0));
    check("busy",      32'(busy),      32'(m_active));
    check("buf_wr_en", 32'(buf_wr_en), 32'(m_wr));
    if (m_wr) begin
      check("buf_wr_addr", 32'(buf_wr_addr), 32'(m_addr));
      check("buf_wr_a",    32'(buf_wr_a),    32'(m_a));
      check("buf_wr_b",    32'(buf_wr_b),    32'(m_b));
    end
    check("arr_rst",   32'(arr_rst),   32'(ph && edge_n == t_w));
    check("buf_read",  32'(buf_read),  32'(ph && edge_n > t_w && edge_n <= t_w + FEED));
    check("feed_step", 32'(feed_step), 32'(e_step));
    check("result_ld", 32'(result_ld), 32'(ph && edge_n == t_w + FEED + DRAIN + 1));
    check("done",      32'(done),      32'(ph && edge_n == t_w + FEED + DRAIN + 2));
    if (buf_wr_en === 1'b1) begin
      cnt_wr++;
      if (nominal_data) begin
        check("nominal_a", 32'(buf_wr_a), 32'(buf_wr_addr) + 32'd1);
        check("nominal_b", 32'(buf_wr_b), 32'(buf_wr_addr) + 32'd17);
      end
    end
    if (arr_rst === 1'b1)   cnt_arr++;
    if (buf_read === 1'b1)  cnt_read++;
    if (result_ld === 1'b1) cnt_res++;
    if (done === 1'b1)      cnt_done++;
  endtask

  initial forever begin
    @(negedge clk);
    compare();
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'($urandom_range(1));
      in_a     = DW'($urandom);
      in_b     = DW'($urandom);
    end
  endtask

  // mode 0: back-to-back, 1: every other cycle, 2: random with pct density.
  task automatic start_and_load(input int mode, input int pct, input bit nominal,
                                input bit extra, output int start_edge, output int last_edge);
    int sent, cyc;
    cnt_wr = 0; cnt_arr = 0; cnt_read = 0; cnt_res = 0; cnt_done = 0;
    nominal_data = nominal;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
    start_edge = edge_n + 1;
    last_edge  = -1;
    @(negedge clk);
    start = 1'b0;
    sent = 0; cyc = 0;
    while (sent < NN && cyc < 400) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = ($urandom_range(99) < pct);
      endcase
      in_a = nominal ? DW'(sent + 1)  : DW'($urandom);
      in_b = nominal ? DW'(sent + 17) : DW'($urandom);
      if (in_valid && in_ready === 1'b1) begin
        sent++;
        if (sent == NN) last_edge = edge_n + 1;
      end
      @(negedge clk);
      cyc++;
    end
    if (sent < NN) check("load_timeout", 32'(sent), 32'(NN));
    in_valid = extra;
    in_a = DW'($urandom);
    in_b = DW'($urandom);
  endtask

  task automatic run_job(input int mode, input int pct, input bit nominal,
                         input bit extra, input bit poke);
    int start_edge, last_edge, done_edge, guard;
    start_and_load(mode, pct, nominal, extra, start_edge, last_edge);
    done_edge = -1;
    guard = 0;
    while (done_edge < 0 && guard < 200) begin
      start = (poke && buf_read === 1'b1 && feed_step == 8'd3);
      if (done === 1'b1) begin
        done_edge = edge_n;
        start = poke;
      end else begin
        @(negedge clk);
        guard++;
      end
    end
    if (done_edge < 0) check("done_timeout", 32'(guard), 32'(0));
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    idle(poke ? 40 : 2);
    nominal_data = 0;
    check("job_writes",    32'(cnt_wr),   32'd16);
    check("job_arr_rst",   32'(cnt_arr),  32'd1);
    check("job_buf_read",  32'(cnt_read), 32'd10);
    check("job_result_ld", 32'(cnt_res),  32'd1);
    check("job_done",      32'(cnt_done), 32'd1);
    check("job_idle_busy", 32'(busy),     32'd0);
    if (done_edge >= 0) begin
      check("lastwr_to_done", 32'(done_edge - last_edge), 32'd16);
      if (mode == 0) check("start_to_done", 32'(done_edge - start_edge), 32'd32);
    end
  endtask

  task automatic reset_mid_feed();
    int start_edge, last_edge, guard;
    start_and_load(2, 70, 1'b0, 1'b0, start_edge, last_edge);
    in_valid = 1'b0;
    guard = 0;
    while (!(buf_read === 1'b1 && feed_step == 8'd4) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("reach_feed", 32'(buf_read), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_buf_read",  32'(buf_read),  32'd0);
    check("rst_feed_step", 32'(feed_step), 32'd0);
    check("rst_done",      32'(done),      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    check("post_rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy",     32'(busy),      32'd0);
    check("reset_in_ready", 32'(in_ready),  32'd0);
    check("reset_wr_en",    32'(buf_wr_en), 32'd0);
    check("reset_addr",     32'(buf_wr_addr), 32'd0);
    rst = 1'b0;
    idle(3);

    run_job(0, 100, 1'b1, 1'b0, 1'b0);   // nominal, A=1..16, B=17..32
    idle(4);
    run_job(1, 100, 1'b1, 1'b0, 1'b0);   // in_valid every other cycle
    idle(3);
    run_job(0, 100, 1'b0, 1'b1, 1'b0);   // in_valid held high past the 16th pair
    idle(3);
    run_job(0, 100, 1'b0, 1'b0, 1'b1);   // start poked in FEED and in DONE
    reset_mid_feed();

    for (int j = 0; j < 6; j++) begin
      run_job(2, 30 + int'($urandom_range(70)), 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      idle(1 + int'($urandom_range(4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
